// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the multi-cycle core fetch unit: state encoding,
// instruction size, address alignment mask and the default boot address.
package cpu_fetch_pkg;

    // Fetch FSM states; encoding is fixed so checkers can decode it directly.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instr_fetch_multi_cycle.sv
// Fetch initiator for the multi-cycle core.
// Owns the PC, issues word-aligned requests over mem_req/mem_ack, captures the
// returned word into the instruction register and offers it to decode.
//
// Handshakes:
//   memory : a request is outstanding while mem_req=1; it completes in the
//            first cycle mem_ack=1 (possibly the same cycle mem_req rises).
//            mem_addr is held stable until that cycle. mem_ack seen while
//            mem_req=0 is ignored.
//   decode : out_valid=1 offers out_instr/out_pc/out_pc_plus4; the transfer
//            happens on a cycle with out_valid=1, out_ready=1 and no redirect.
//            Until then the offered values do not change and out_valid does
//            not drop unless a redirect kills the instruction.
module instr_fetch_multi_cycle
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
    output logic [CNT_W-1:0] fetch_cnt
);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      drop_addr_q, drop_addr_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      opc_q, opc_d;
    logic [31:0]      opc4_q, opc4_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      pc_next_seq;
    logic [31:0]      redirect_tgt;

    assign pc_next_seq  = pc_q + 32'(INSTR_BYTES);
    assign redirect_tgt = align_pc(redirect_pc);

    // While an abandoned request drains, the memory keeps seeing its address;
    // otherwise the address is the PC register. No redirect input reaches it.
    assign mem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

    assign out_instr    = instr_q;
    assign out_pc       = opc_q;
    assign out_pc_plus4 = opc4_q;
    assign fetch_cnt    = cnt_q;

    // State and datapath registers; reset discards any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'h0;
            instr_q     <= 32'h0;
            opc_q       <= 32'h0;
            opc4_q      <= 32'h0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            instr_q     <= instr_d;
            opc_q       <= opc_d;
            opc4_q      <= opc4_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state, datapath updates and per-state request/valid outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        opc4_d      = opc4_q;
        cnt_d       = cnt_q;
        mem_req     = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A response arriving now is simply not captured; one
                    // still owed must be drained before the next request.
                    if (!mem_ack) begin
                        drop_addr_d = pc_q;
                        state_d     = ST_DROP;
                    end
                end else if (mem_ack) begin
                    instr_d = mem_rdata;
                    opc_d   = pc_q;
                    opc4_d  = pc_next_seq;
                    pc_d    = pc_next_seq;
                    state_d = ST_VALID;
                end
            end

            ST_DROP: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = ST_FETCH;
                end
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end

            ST_VALID: begin
                out_valid = 1'b1;
                // A redirect kills the offered instruction even if decode
                // is ready in the same cycle.
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = ST_FETCH;
                end else if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule
